// File: rtl/spi_slave.sv
// SPI responder running entirely on clk: SCLK/SS/MOSI are synchronised and edge-detected,
// 8-bit LSB-first frames in all four modes, single-entry reply buffer, one-cycle rx strobe.
module spi_slave (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       sclk_i,
    input  logic       ss_i,
    input  logic       mosi_i,
    input  logic [1:0] mode_i,
    input  logic [7:0] din_i,
    input  logic       din_valid_i,
    output wire logic  miso_o,
    output logic [7:0] dout_o,
    output logic       rx_valid_o,
    output logic       busy_o
);
    typedef enum logic [1:0] {StIdle, StActive, StWaitHigh} state_e;

    state_e     state_q, state_d;
    logic       sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic       ss_s1_q, ss_s2_q, ss_s3_q;
    logic       mosi_s1_q, mosi_s2_q;
    logic [1:0] fill_q;
    logic [1:0] mode_q, mode_d;
    logic [7:0] tx_buf_q;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic [2:0] cnt_q, cnt_d;
    logic       first_q, first_d;
    logic [7:0] dout_q, dout_d;
    logic       done_q, done_d;
    logic       rx_valid_q;

    logic sync_ok, ss_fall, ss_rise, sclk_edge, cpol, cpha;
    logic lead_edge, trail_edge, sample, reload, shift;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_s3_q <= 1'b0;
            ss_s1_q   <= 1'b1;
            ss_s2_q   <= 1'b1;
            ss_s3_q   <= 1'b1;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
            fill_q    <= 2'b00;
        end else begin
            sclk_s1_q <= sclk_i;
            sclk_s2_q <= sclk_s1_q;
            sclk_s3_q <= sclk_s2_q;
            ss_s1_q   <= ss_i;
            ss_s2_q   <= ss_s1_q;
            ss_s3_q   <= ss_s2_q;
            mosi_s1_q <= mosi_i;
            mosi_s2_q <= mosi_s1_q;
            fill_q    <= {fill_q[0], 1'b1};
        end
    end

    // The forced-high SS reset value must flush out before SS low can be trusted;
    // otherwise a master already mid-frame would look like a fresh frame start.
    assign sync_ok    = fill_q[1];
    assign ss_fall    = ~ss_s2_q & ss_s3_q;
    assign ss_rise    = ss_s2_q & ~ss_s3_q;
    assign sclk_edge  = sclk_s2_q ^ sclk_s3_q;
    assign cpol       = mode_q[1];
    assign cpha       = mode_q[0];
    assign lead_edge  = sclk_edge & (sclk_s2_q != cpol);
    assign trail_edge = sclk_edge & (sclk_s2_q == cpol);
    assign sample     = cpha ? trail_edge : lead_edge;
    // Trailing edge of bit 7: with CPHA=0 all eight samples are already taken.
    assign reload     = trail_edge & (cpha ? (cnt_q == 3'd7) : ((cnt_q == 3'd0) & ~first_q));
    assign shift      = cpha ? (lead_edge & ~first_q) : (trail_edge & ~reload);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ss_fall) begin
                    state_d = StActive;
                    mode_d  = mode_i;
                    tx_d    = tx_buf_q;
                    cnt_d   = 3'd0;
                    first_d = 1'b1;
                end
            end
            StActive: begin
                if (ss_rise) begin
                    state_d = StIdle;
                end else begin
                    if (sample) begin
                        rx_d  = {mosi_s2_q, rx_q[7:1]};
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            dout_d = {mosi_s2_q, rx_q[7:1]};
                            done_d = 1'b1;
                        end
                    end
                    if (lead_edge) begin
                        first_d = 1'b0;
                    end
                    if (reload) begin
                        tx_d    = tx_buf_q;
                        first_d = 1'b1;
                    end else if (shift) begin
                        tx_d = {1'b0, tx_q[7:1]};
                    end
                end
            end
            StWaitHigh: begin
                if (sync_ok && ss_s2_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StWaitHigh;
            mode_q     <= 2'b00;
            tx_buf_q   <= 8'h00;
            tx_q       <= 8'h00;
            rx_q       <= 8'h00;
            cnt_q      <= 3'd0;
            first_q    <= 1'b0;
            dout_q     <= 8'h00;
            done_q     <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            cnt_q      <= cnt_d;
            first_q    <= first_d;
            dout_q     <= dout_d;
            done_q     <= done_d;
            rx_valid_q <= done_q;
            if (din_valid_i) begin
                tx_buf_q <= din_i;
            end
        end
    end

    assign miso_o     = (state_q == StActive) ? tx_q[0] : 1'bz;
    assign dout_o     = dout_q;
    assign rx_valid_o = rx_valid_q;
    assign busy_o     = (state_q == StActive);

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI slave (responder) for the SPI master's bus: receives MOSI bytes and returns MISO bytes, LSB first, in all four SPI modes. It runs entirely on the system clock: SCLK, SS and MOSI are treated as asynchronous inputs, synchronised and edge-detected. Received bytes go to the local logic through a one-cycle valid strobe. The next reply byte is written through a single-entry transmit buffer.

## Interface
- No parameters; frame width fixed at 8 bits, bit order LSB first.
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- SCLK  input  1  serial clock from master, asynchronous to clk.
- SS  input  1  slave select, active low, asynchronous.
- MOSI  input  1  serial data from master, asynchronous.
- mode  input  2  SPI mode:
  - mode[1] = CPOL, the SCLK idle level.
  - mode[0] = CPHA: 0 = sample on leading edge; 1 = sample on trailing edge.
- din  input  8  next reply byte.
- din_valid  input  1  writes din into the transmit buffer this cycle.
- MISO  output  1  serial data to master; high-impedance (z) while not in ACTIVE.
- dout  output  8  last complete received byte; holds until the next byte completes.
- rx_valid  output  1  one-cycle pulse when dout updates.
- busy  output  1  high while state = ACTIVE.

## Operation
- Synchronisers: SCLK, SS and MOSI each pass through 2 flops (s1, s2). A third register on SCLK and SS gives edge detection (s2 != s3).
- Leading edge: SCLK leaves its CPOL level. Trailing edge: SCLK returns to its CPOL level.
- States:
  - IDLE: SS high, MISO = z.
  - ACTIVE: frame in progress.
  - WAIT_HIGH: SS low but no valid frame start seen.
- Transitions:
  - IDLE -> ACTIVE on a synced SS falling edge. On this transition: latch mode into mode_r, load tx_reg from tx_buf, set bit_cnt = 0, set first = 1.
  - ACTIVE -> IDLE on a synced SS rising edge.
  - WAIT_HIGH -> IDLE when synced SS = 1.
  - reset -> IDLE if synced SS is high; otherwise -> WAIT_HIGH. A master already mid-frame is ignored until SS deasserts.
- MISO in ACTIVE = tx_reg[0].
- Shift-out event (shift tx_reg right by 1):
  - CPHA=0: every trailing edge.
  - CPHA=1: every leading edge except the first leading edge of each byte (tracked by flag `first`, cleared on that edge).
- Sample event: rx_sh = {MOSI_s2, rx_sh[7:1]}, then bit_cnt++.
  - CPHA=0: on leading edges.
  - CPHA=1: on trailing edges.
- Byte completion, on the sample that brings bit_cnt 7 -> 0:
  - dout <= completed byte; rx_valid = 1 the following cycle.
- Byte boundary (multi-byte frames with SS held low):
  - On the trailing edge of bit 7, reload tx_reg from tx_buf instead of shifting, and set first = 1. This applies in both CPHA modes.
- Transmit buffer:
  - din_valid writes tx_buf in any state.
  - A write in the same cycle as a reload: the reload takes the old tx_buf; the new value is used for the following byte.
  - If no write occurs between reloads, the same byte is resent.
- Abort: SS rising with bit_cnt != 0 discards the partial byte. No rx_valid, dout unchanged.
- mode changes while ACTIVE are ignored (mode_r is used). Any SCLK edge in IDLE or WAIT_HIGH is ignored.
- Reset values: MISO = z, dout = 0x00, rx_valid = 0, busy = 0, tx_buf = 0x00, tx_reg = 0x00, bit_cnt = 0, synchroniser flops = 1 (SS), CPOL-independent 0 (SCLK, MOSI).

## Timing
- Let E be the first clk posedge that samples a new level on a pin.
- Edge detect fires at E+2; the state update happens on that edge.
- MISO changes at E+2 for both shift and reload.
- rx_valid is high during the cycle after E+2, i.e. it is registered at E+3; pulse width is exactly 1 clk.
- SS falling: busy = 1 and MISO driven with tx_buf[0] from E+2.
- SS rising: busy = 0 and MISO = z from E+2.
- Master requirements:
  - SCLK high and low times >= 4 clk periods.
  - SS setup to the first SCLK edge >= 4 clk.
  - SS hold after the last SCLK edge >= 4 clk.
  - MOSI stable >= 3 clk before its sampling SCLK edge.
- Out-of-spec timing (e.g. an SCLK half period of 1 clk) is unsupported. The bench master model must meet the figures above.
- Reset asserted mid-frame takes priority over all events in that cycle. rx_valid does not fire for the interrupted byte.

## Test plan
- Mode 0, tx_buf = 0xA5, master sends 0x3C LSB first -> dout = 0x3C with a single rx_valid pulse; master receives 0xA5; MISO = z after SS high.
- Modes 1, 2 and 3, each with tx_buf = 0x81 and MOSI byte 0x7E -> dout = 0x7E and MISO byte 0x81 in every mode; no extra bit and no shifted-by-one result.
- Two bytes with SS held low (MOSI 0x11 then 0x22), with din_valid writing 0x55 then 0x66 before each byte boundary -> rx_valid pulses twice (dout 0x11, then 0x22); master receives 0x55 then 0x66.
- Abort after 5 SCLK cycles (SS rises), then a full frame of 0xF0 -> no rx_valid for the aborted byte; the next frame gives dout = 0xF0 and the tx byte restarts from bit 0.
- Assert reset at bit 3 while SS is low and SCLK keeps toggling -> outputs at reset values; state stays WAIT_HIGH until SS rises; the next frame receives correctly.
- Change mode mid-frame, and toggle SCLK while SS is high -> no effect on the data of the current frame; no rx_valid from the SS-high toggling.
